data_mem_responder: RTL

//  - Memory-side responder for the rd/wr strobes issued by control_unit.
//  - Single-port word memory: sequences each access through programmable wait

---
 rtl/data_mem_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for the rd/wr strobes of the control
//               unit. Single-port word memory that captures one request in
//               IDLE, waits WAIT_CYCLES cycles, then completes it with a
//               one-cycle ready pulse. Read data is returned on rdata, and
//               failed accesses raise err.
//
//   Optional feature (macro DMEM_WRITE_PROTECT_EN):
//               adds input wp. A write captured with wp=1 to an address below
//               WP_LIMIT completes with err=1 and leaves memory unchanged.
//
//   Ports:
//     clk    in   1       rising-edge clock
//     rst    in   1       asynchronous reset, active-high
//     wp     in   1       write-protect enable (only with the macro)
//     rd     in   1       read request, sampled in IDLE only
//     wr     in   1       write request, sampled in IDLE only
//     addr   in   ADDR_W  word address, captured with the request
//     wdata  in   DATA_W  write data, captured with the request
//     rdata  out  DATA_W  read data, held until the next good read completes
//     ready  out  1       one-cycle completion pulse
//     err    out  1       error flag, only ever high together with ready
//     busy   out  1       high from capture through the ready cycle
//
//   Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int WP_LIMIT    = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DMEM_WRITE_PROTECT_EN
    input  logic              wp,
`endif
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int c_IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int c_CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    localparam logic [ADDR_W:0]    c_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    c_WP_LIMIT  = (ADDR_W + 1)'(WP_LIMIT);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_CYCLES);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;

    // Captured request
    logic               r_wr;
    logic               r_err;
    logic [c_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_wp;
    logic               w_start;
    logic               w_capture;
    logic               w_oor;
    logic               w_wp_err;
    logic               w_cap_err;
    logic               w_cur_wr;
    logic               w_cur_err;
    logic [c_IDX_W-1:0] w_cur_idx;
    logic               w_ld_rdata;
    logic               w_mem_we;

`ifdef DMEM_WRITE_PROTECT_EN
    assign w_wp = wp;
`else
    assign w_wp = 1'b0;
`endif

    // Error classification happens at capture, so only in-range index bits
    // need to be kept afterwards.
    assign w_start   = rd | wr;
    assign w_capture = (r_state == c_ST_IDLE) && w_start;
    assign w_oor     = ({1'b0, addr} >= c_DEPTH);
    assign w_wp_err  = w_wp & wr & ~rd & ({1'b0, addr} < c_WP_LIMIT);
    assign w_cap_err = (rd & wr) | w_oor | w_wp_err;

    // With zero wait states RESP is entered on the capture edge itself, so the
    // read path must see the live request rather than the captured copy.
    assign w_cur_wr  = (r_state == c_ST_IDLE) ? wr : r_wr;
    assign w_cur_err = (r_state == c_ST_IDLE) ? w_cap_err : r_err;
    assign w_cur_idx = (r_state == c_ST_IDLE) ? addr[c_IDX_W-1:0] : r_idx;

    assign w_ld_rdata = (w_state_nxt == c_ST_RESP) && (r_state != c_ST_RESP)
                        && !w_cur_wr && !w_cur_err;

    // The write lands on the edge leaving RESP; a reset at that edge aborts it.
    assign w_mem_we = (r_state == c_ST_RESP) && r_wr && !r_err && !rst;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and wait counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = r_cnt + 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = c_ST_RESP;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (w_cnt_inc == c_WAIT_LAST) begin
                    w_state_nxt = c_ST_RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and read data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_wr    <= wr;
                r_err   <= w_cap_err;
                r_idx   <= addr[c_IDX_W-1:0];
                r_wdata <= wdata;
            end
            if (w_ld_rdata) begin
                r_rdata <= r_mem[w_cur_idx];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ready = (r_state == c_ST_RESP);
    assign err   = (r_state == c_ST_RESP) && r_err;
    assign busy  = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
